// File: rtl/rv32_imm_arbiter.sv
// rv32_imm_arbiter: round-robin sharing of one combinational RV32 immediate
// generator among NUM_REQ requesters. Each grant is captured into a single
// output register that is tagged with the requester index and drained through
// a valid/ready handshake.
// Optional: RV32_IMM_ARB_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
// It counts the cycles in which requests are pending but the output register
// cannot accept a new result.
module rv32_imm_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned XLEN    = 32,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_instr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [XLEN-1:0]         imm_instr,
  input  logic [XLEN-1:0]         imm_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_imm,
`ifdef RV32_IMM_ARB_STALL_CNT_EN
  output logic [31:0]             stall_cnt,
`endif
  input  logic                    rsp_ready
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic            any_req;
  logic            can_accept;
  logic            grant;
  int unsigned     idx;
  logic [XLEN-1:0] instr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign instr_arr[g] = req_instr[g*XLEN +: XLEN];
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign grant      = any_req && can_accept;

  // Rotating priority search: the first valid request at or after rr_ptr wins.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        win     = idx[ID_W-1:0];
      end
    end
  end

  // The grant is one-hot and is gated by can_accept. The generator is fed
  // from the winner even while the grant is blocked.
  always_comb begin
    req_ready = '0;
    imm_instr = '0;
    if (any_req) begin
      imm_instr = instr_arr[win];
      if (can_accept) req_ready[win] = 1'b1;
    end
  end

  // Output register and round-robin pointer. A grant overwrites the register
  // in the same cycle that it is consumed, so no bubble is inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_imm   <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win;
      rsp_imm   <= imm_result;
      rr_ptr    <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef RV32_IMM_ARB_STALL_CNT_EN
  // Saturating count of cycles with pending requests that are blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (|req_valid && !can_accept && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_imm_arbiter.sv
// Directed self-checking bench for rv32_imm_arbiter (NUM_REQ=8, XLEN=32).
module tb_rv32_imm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req_valid;
  logic [31:0] instr [8];
  logic [255:0] req_instr;
  logic [7:0]  req_ready;
  logic [31:0] imm_instr;
  logic [31:0] imm_result;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [31:0] rsp_imm;
  logic        rsp_ready;
`ifdef RV32_IMM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_instr = '0;
    for (int i = 0; i < 8; i++) req_instr[i*32 +: 32] = instr[i];
  end

  // Stand-in for the shared RV32 immediate generator.
  function automatic logic [31:0] immgen(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: immgen = {{20{i[31]}}, i[31:20]};
      7'h23:               immgen = {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:               immgen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        immgen = {i[31:12], 12'b0};
      7'h6F:               immgen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:             immgen = '0;
    endcase
  endfunction

  always_comb imm_result = immgen(imm_instr);

  rv32_imm_arbiter #(.NUM_REQ(8), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_instr(req_instr),
    .req_ready(req_ready),
    .imm_instr(imm_instr),
    .imm_result(imm_result),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_imm(rsp_imm),
`ifdef RV32_IMM_ARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .rsp_ready(rsp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) instr[i] = '0;
    #12;
    compared++;
    if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_imm !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_regs: valid=%b id=%0d imm=%h, required 0/0/0", rsp_valid, rsp_id, rsp_imm);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (req_ready !== 8'h00 || imm_instr !== 32'd0) begin
      mismatched++;
      $display("FAIL idle_outputs: req_ready=%h imm_instr=%h, required 00/0", req_ready, imm_instr);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    instr[3] = 32'hFFF00093;
    req_valid = 8'h08;
    rsp_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 8'h08 || imm_instr !== 32'hFFF00093) begin
      mismatched++;
      $display("FAIL single_grant: req_ready=%h imm_instr=%h, required 08/fff00093", req_ready, imm_instr);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd3 || rsp_imm !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL single_rsp: valid=%b id=%0d imm=%h, required 1/3/ffffffff", rsp_valid, rsp_id, rsp_imm);
    end
    @(negedge clk);
    req_valid = '0;
    tick();
    compared++;
    if (rsp_valid !== 1'b0 || rsp_id !== 3'd3 || rsp_imm !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL consume_only: valid=%b id=%0d imm=%h, required 0/3/ffffffff", rsp_valid, rsp_id, rsp_imm);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id;
    do_reset();
    for (int i = 0; i < 8; i++) instr[i] = (32'(i) << 12) | 32'h0B7;
    req_valid = 8'hFF;
    rsp_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 8'h01) begin
      mismatched++;
      $display("FAIL rr_first_ready: req_ready=%h, required 01", req_ready);
    end
    for (int k = 0; k < 9; k++) begin
      exp_id = 3'(k % 8);
      tick();
      compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_imm !== (32'(exp_id) << 12)
          || req_ready !== (8'h01 << ((k + 1) % 8))) begin
        mismatched++;
        $display("FAIL rr_step%0d: valid=%b id=%0d imm=%h ready=%h, required 1/%0d/%h/%h", k,
                 rsp_valid, rsp_id, rsp_imm, req_ready, exp_id, 32'(exp_id) << 12,
                 8'h01 << ((k + 1) % 8));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr[0] = 32'h00500093;
    instr[2] = 32'hFE20AC23;
    req_valid = 8'h05;
    rsp_ready = 1'b0;
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_imm !== 32'd5) begin
      mismatched++;
      $display("FAIL bp_first: valid=%b id=%0d imm=%h, required 1/0/5", rsp_valid, rsp_id, rsp_imm);
    end
    for (int k = 0; k < 5; k++) begin
      compared++;
      if (req_ready !== 8'h00 || rsp_id !== 3'd0 || rsp_imm !== 32'd5 || rsp_valid !== 1'b1
          || imm_instr !== 32'hFE20AC23) begin
        mismatched++;
        $display("FAIL bp_hold%0d: ready=%h id=%0d imm=%h valid=%b instr=%h, required 00/0/5/1/fe20ac23",
                 k, req_ready, rsp_id, rsp_imm, rsp_valid, imm_instr);
      end
      tick();
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 8'h04) begin
      mismatched++;
      $display("FAIL bp_release_ready: req_ready=%h, required 04", req_ready);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_imm !== 32'hFFFFFFF8) begin
      mismatched++;
      $display("FAIL bp_release_rsp: valid=%b id=%0d imm=%h, required 1/2/fffffff8", rsp_valid, rsp_id, rsp_imm);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) instr[i] = (32'(i + 16) << 12) | 32'h0B7;
    rsp_ready = 1'b1;
    req_valid = 8'h80;
    tick();
    compared++;
    if (rsp_id !== 3'd7 || rsp_imm !== 32'h00017000) begin
      mismatched++;
      $display("FAIL wrap_seed: id=%0d imm=%h, required 7/00017000", rsp_id, rsp_imm);
    end
    @(negedge clk);
    req_valid = 8'h81;
    tick();
    compared++;
    if (rsp_id !== 3'd0 || rsp_imm !== 32'h00010000) begin
      mismatched++;
      $display("FAIL wrap_to0: id=%0d imm=%h, required 0/00010000", rsp_id, rsp_imm);
    end
    tick();
    compared++;
    if (rsp_id !== 3'd7 || rsp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_then7: id=%0d valid=%b, required 7/1", rsp_id, rsp_valid);
    end
    tick();
    compared++;
    if (rsp_id !== 3'd0) begin
      mismatched++;
      $display("FAIL wrap_again0: id=%0d, required 0", rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr[3] = 32'h12345037;
    instr[5] = 32'h00700013;
    req_valid = 8'h08;
    rsp_ready = 1'b1;
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd3 || rsp_imm !== 32'h12345000) begin
      mismatched++;
      $display("FAIL mid_pre: valid=%b id=%0d imm=%h, required 1/3/12345000", rsp_valid, rsp_id, rsp_imm);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 8'h28;
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_imm !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_async: valid=%b id=%0d imm=%h, required 0/0/0", rsp_valid, rsp_id, rsp_imm);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd3) begin
      mismatched++;
      $display("FAIL mid_ptr0: valid=%b id=%0d, required 1/3", rsp_valid, rsp_id);
    end
  endtask

`ifdef RV32_IMM_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    instr[1] = 32'h00100093;
    req_valid = 8'h02;
    rsp_ready = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) tick();
    compared++;
    if (stall_cnt !== 32'd10) begin
      mismatched++;
      $display("FAIL stall_cnt: got %0d, required 10", stall_cnt);
    end
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef RV32_IMM_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
      end
      begin
        #20000;
        $display("FAIL timeout: run exceeded 20000 time units, required completion");
        $fatal(1, "timeout");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv32_imm_arbiter.md
Name: rv32_imm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational RV32 immediate generator among NUM_REQ requesters (per-hart decode slots in the barrel core).
- Grants one requester per cycle and drives the winning instruction to the shared generator.
- Captures the decoded immediate into a single-entry output register, tagged with the requester index, under a valid/ready response handshake.

Parameters:
- NUM_REQ, 8, number of requesters (>=2)
- XLEN, 32, instruction/immediate width
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_instr  in  NUM_REQ*XLEN  packed instructions; requester i at bits [i*XLEN +: XLEN]
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i] && req_ready[i]
- imm_instr  out  XLEN  instruction to the shared immediate generator
- imm_result  in  XLEN  generator result, combinational from imm_instr
- rsp_valid  out  1  output register holds a result
- rsp_id  out  ID_W  requester index of the held result
- rsp_imm  out  XLEN  held immediate
- rsp_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_imm=0, rr_ptr=0. req_ready follows its combinational rule and is therefore 0 while rsp_valid=0 and no req_valid is set.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Arbitration:
  - Search req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins.
  - req_ready[win]=1 only if can_accept; all other req_ready bits are 0.
  - req_ready never depends on req_instr.
- imm_instr = req_instr of the winner whenever any req_valid is set, regardless of can_accept. Otherwise imm_instr = 0.
- On grant (any req_valid && can_accept), at the clock edge:
  - rsp_imm <= imm_result
  - rsp_id <= win
  - rsp_valid <= 1
  - rr_ptr <= win+1, wrapping to 0 at NUM_REQ
- Latency: grant in cycle N gives rsp_valid=1 in cycle N+1.
- Throughput: one result per cycle when rsp_ready is held high.
- Consume without grant (rsp_valid && rsp_ready, no req_valid): rsp_valid <= 0. rsp_id and rsp_imm hold their values.
- Simultaneous consume and grant in the same cycle: the register is overwritten with the new result and rsp_valid stays 1. No bubble.
- Backpressure (rsp_valid && !rsp_ready):
  - all req_ready = 0
  - rsp_id, rsp_imm, rr_ptr hold
  - rsp_imm stays stable while rsp_valid=1 && !rsp_ready
- Requesters hold req_valid and req_instr until their handshake completes. The arbiter does not latch requests.
- No grant: rr_ptr holds.
- Single active requester: granted every accepting cycle.
- All requesters active: grants rotate i, i+1, ..., wrap. Starvation bound is NUM_REQ-1 grants.
- Reset asserted mid-transfer: the held result is discarded (rsp_valid=0) and the pointer returns to 0. Requests pending at deassertion are arbitrated from index 0.

Optional Feature:
- Macro: RV32_IMM_ARB_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt (32 bits).
  - Counts cycles where |req_valid && !can_accept.
  - Saturates at 32'hFFFF_FFFF and resets to 0.
  - Counting is independent of the grant path.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: assert rst mid-cycle with rsp_valid=1 -> rsp_valid=0, rsp_imm=0, rsp_id=0 immediately (async). After release with no req_valid -> req_ready=0, imm_instr=0.
- Single I-type: req_valid[3]=1, req_instr[3]=32'hFFF00093 (addi x1,x0,-1), rsp_ready=1 -> req_ready=8'h08 same cycle. Next cycle rsp_valid=1, rsp_id=3, rsp_imm=32'hFFFFFFFF.
- Round-robin: req_valid=8'hFF, each req_instr[i]=U-type lui with imm i, rsp_ready=1 -> rsp_id sequence 0,1,...,7,0 on consecutive cycles, rsp_imm=i<<12, no idle cycles.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 5 cycles, req_valid=8'h05 -> req_ready=0 and rsp_imm/rsp_id stable for all 5 cycles. On rsp_ready=1, the same-cycle grant goes to the requester after the last winner, and rsp_valid stays 1.
- Pointer wrap: last grant to 7, then req_valid=8'h81 -> grant to 0, then 7.
- Stall counter (macro defined): 10 blocked cycles with req_valid!=0 -> stall_cnt=10. Preload near max -> holds 32'hFFFFFFFF.
